// File: rtl/sr_latch_arbiter_if.sv
// sr_latch_arbiter_if
// Bundles the requester handshake and the gated SR latch pins.
// slave  : the arbiter side (sees requests and q, drives ack/err/status/s/r/e).
// master : the agent + latch side (drives req/op and the q readback).
interface sr_latch_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] op;
    logic [NREQ-1:0] ack;
    logic            err;
    logic [GW-1:0]   grant_id;
    logic            busy;
    logic            s;
    logic            r;
    logic            e;
    logic            q;

    modport slave (
        input  req, op, q,
        output ack, err, grant_id, busy, s, r, e
    );

    modport master (
        output req, op, q,
        input  ack, err, grant_id, busy, s, r, e
    );
endinterface

// File: rtl/sr_latch_arbiter.sv
// sr_latch_arbiter
// Round-robin owner of one gated SR latch shared by NREQ requesters.
// Each operation is sequenced SETUP (s/r settle) -> PULSE (e high for
// PULSE_CYC cycles) -> HOLD (e low, s/r kept) -> CHECK (q compared, ack).
// s and r are always complementary or both zero, so they are never both 1.
// Optional build macro SR_ARB_SKIP_REDUNDANT_EN: when the latch already holds
// the requested value, the grant goes straight to CHECK without touching e.
module sr_latch_arbiter #(
    parameter int NREQ      = 4,
    parameter int PULSE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    sr_latch_arbiter_if.slave    bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        CHECK = 3'd4
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_ptr;
    logic [GW-1:0]   r_grant;
    logic            r_op;
    logic [CW-1:0]   r_cnt;
    logic [NREQ-1:0] r_ack;
    logic            r_err;
    logic            r_busy;
    logic            r_s;
    logic            r_r;
    logic            r_e;

    logic            w_any;
    logic [GW-1:0]   w_sel;
    logic            w_sel_op;
    logic            w_skip;

    // First set request bit at or above ptr, wrapping modulo NREQ.
    function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] rq,
                                              input logic [GW-1:0]   ptr);
        logic [GW-1:0] pick;
        logic [GW-1:0] k;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            k = GW'(idx);
            if (!found && rq[k]) begin
                pick  = k;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Next round-robin start position after serving index g.
    function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] g);
        logic [GW-1:0] nxt;
        if (g == GW'(NREQ - 1)) begin
            nxt = '0;
        end else begin
            nxt = g + 1'b1;
        end
        return nxt;
    endfunction

    assign w_any    = |bus.req;
    assign w_sel    = rr_pick(bus.req, r_ptr);
    assign w_sel_op = bus.op[w_sel];

`ifdef SR_ARB_SKIP_REDUNDANT_EN
    assign w_skip = (w_sel_op == bus.q);
`else
    assign w_skip = 1'b0;
`endif

    // Operation sequencer: all latch pins and status are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_op    <= 1'b0;
            r_cnt   <= '0;
            r_ack   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_e     <= 1'b0;
        end else begin
            // ack/err are single-cycle pulses unless re-raised below.
            r_ack <= '0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_s <= 1'b0;
                    r_r <= 1'b0;
                    r_e <= 1'b0;
                    if (w_any) begin
                        r_grant <= w_sel;
                        r_op    <= w_sel_op;
                        r_busy  <= 1'b1;
                        if (w_skip) begin
                            // Latch already holds the value: acknowledge at once.
                            r_state        <= CHECK;
                            r_ack[w_sel]   <= 1'b1;
                            r_ptr          <= wrap_inc(w_sel);
                        end else begin
                            r_state <= SETUP;
                            r_s     <= w_sel_op;
                            r_r     <= ~w_sel_op;
                        end
                    end
                end
                SETUP: begin
                    r_state <= PULSE;
                    r_e     <= 1'b1;
                    r_cnt   <= '0;
                end
                PULSE: begin
                    if (r_cnt == CW'(PULSE_CYC - 1)) begin
                        r_state <= HOLD;
                        r_e     <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    // Enable has been low for a cycle, q is now stable to read.
                    r_state        <= CHECK;
                    r_s            <= 1'b0;
                    r_r            <= 1'b0;
                    r_ack[r_grant] <= 1'b1;
                    r_err          <= (bus.q != r_op);
                    r_ptr          <= wrap_inc(r_grant);
                end
                CHECK: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_s     <= 1'b0;
                    r_r     <= 1'b0;
                    r_e     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack      = r_ack;
    assign bus.err      = r_err;
    assign bus.grant_id = r_grant;
    assign bus.busy     = r_busy;
    assign bus.s        = r_s;
    assign bus.r        = r_r;
    assign bus.e        = r_e;

endmodule

// File: tb/tb_sr_latch_arbiter.sv
// tb_sr_latch_arbiter
// Directed bench for sr_latch_arbiter with a behavioural gated SR latch.
// Honours SR_ARB_SKIP_REDUNDANT_EN for the redundant-operation case.
module tb_sr_latch_arbiter;
    localparam int NREQ      = 4;
    localparam int PULSE_CYC = 2;

    logic clk = 1'b0;
    logic rst;
    logic lat_q  = 1'b0;
    logic stuck0 = 1'b0;
    logic mon_en = 1'b0;
    logic e_seen = 1'b0;
    int   n_chk  = 0;
    int   n_err  = 0;

    always #5 clk = ~clk;

    sr_latch_arbiter_if #(.NREQ(NREQ)) bif ();

    sr_latch_arbiter #(
        .NREQ      (NREQ),
        .PULSE_CYC (PULSE_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // Gated SR latch model; stuck0 forces the readback low.
    always @(posedge clk) begin
        if (bif.e) begin
            if (bif.s)      lat_q <= 1'b1;
            else if (bif.r) lat_q <= 1'b0;
        end
    end
    assign bif.q = stuck0 ? 1'b0 : lat_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per-cycle invariants.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("inv_s_and_r", 32'(bif.s & bif.r), 32'd0);
            check("inv_ack_onehot", 32'($onehot0(bif.ack)), 32'd1);
            check("inv_err_wo_ack", 32'(bif.err & ~(|bif.ack)), 32'd0);
            check("inv_e_idle", 32'(bif.e & ~bif.busy), 32'd0);
            if (bif.e) e_seen = 1'b1;
        end
    end

    task automatic wait_ack(output logic [NREQ-1:0] a, output logic er, output int cyc);
        a   = '0;
        er  = 1'b0;
        cyc = 0;
        while (cyc < 30 && a == '0) begin
            @(negedge clk);
            cyc++;
            a  = bif.ack;
            er = bif.err;
        end
        if (a == '0) check("ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    logic [NREQ-1:0] a;
    logic            er;
    int              cyc;
    int              id;

    initial begin
        rst     = 1'b1;
        bif.req = '0;
        bif.op  = '0;

        // Reset state, then idle for 10 cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ack", 32'(bif.ack), 32'd0);
        check("rst_err", 32'(bif.err), 32'd0);
        check("rst_gid", 32'(bif.grant_id), 32'd0);
        check("rst_busy", 32'(bif.busy), 32'd0);
        check("rst_sre", {29'd0, bif.s, bif.r, bif.e}, 32'd0);
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(bif.busy), 32'd0);
        end

        // Single set by requester 0, phase by phase.
        bif.req = 4'b0001;
        bif.op  = 4'b0001;
        @(negedge clk);
        check("setup_sre", {29'd0, bif.s, bif.r, bif.e}, 32'b100);
        check("setup_busy", 32'(bif.busy), 32'd1);
        check("setup_gid", 32'(bif.grant_id), 32'd0);
        @(negedge clk);
        check("pulse1_sre", {29'd0, bif.s, bif.r, bif.e}, 32'b101);
        @(negedge clk);
        check("pulse2_sre", {29'd0, bif.s, bif.r, bif.e}, 32'b101);
        @(negedge clk);
        check("hold_sre", {29'd0, bif.s, bif.r, bif.e}, 32'b100);
        check("hold_ack", 32'(bif.ack), 32'd0);
        @(negedge clk);
        check("chk_ack", 32'(bif.ack), 32'b0001);
        check("chk_err", 32'(bif.err), 32'd0);
        check("chk_q", 32'(bif.q), 32'd1);
        check("chk_sre", {29'd0, bif.s, bif.r, bif.e}, 32'd0);
        bif.req = '0;
        @(negedge clk);
        check("post_ack", 32'(bif.ack), 32'd0);
        check("post_busy", 32'(bif.busy), 32'd0);
        check("post_gid_hold", 32'(bif.grant_id), 32'd0);

        // All requesting, alternating ops: order 0,1,2,3,0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bif.req = 4'b1111;
        bif.op  = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            wait_ack(a, er, cyc);
            id = k % 4;
            check("rr_ack", 32'(a), 32'(4'b0001 << id));
            check("rr_gid", 32'(bif.grant_id), 32'(id));
            check("rr_err", 32'(er), 32'd0);
            check("rr_q", 32'(bif.q), (id % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_lat", 32'(cyc), (k == 0) ? 32'd5 : 32'd6);
            if (k == 4) bif.req = '0;
        end
        @(negedge clk);
        check("rr_done_busy", 32'(bif.busy), 32'd0);

        // Latch stuck at 0: set by requester 2 reports err with ack.
        stuck0  = 1'b1;
        bif.req = 4'b0100;
        bif.op  = 4'b0100;
        wait_ack(a, er, cyc);
        check("stuck_ack", 32'(a), 32'b0100);
        check("stuck_err", 32'(er), 32'd1);
        check("stuck_lat", 32'(cyc), 32'd5);
        bif.req = '0;
        stuck0  = 1'b0;
        @(negedge clk);

        // Reset during PULSE of requester 1 aborts; pointer returns to 0.
        bif.req = 4'b0010;
        bif.op  = 4'b0010;
        @(negedge clk);
        check("abort_gid", 32'(bif.grant_id), 32'd1);
        @(negedge clk);
        check("abort_in_pulse", 32'(bif.e), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_sre", {29'd0, bif.s, bif.r, bif.e}, 32'd0);
        check("abort_busy", 32'(bif.busy), 32'd0);
        check("abort_ack", 32'(bif.ack), 32'd0);
        check("abort_gid0", 32'(bif.grant_id), 32'd0);
        rst = 1'b0;
        bif.req = 4'b1010;
        bif.op  = 4'b1010;
        wait_ack(a, er, cyc);
        check("reptr_ack1", 32'(a), 32'b0010);
        check("reptr_lat1", 32'(cyc), 32'd5);
        bif.req = 4'b1000;
        wait_ack(a, er, cyc);
        check("reptr_ack3", 32'(a), 32'b1000);
        check("reptr_lat3", 32'(cyc), 32'd6);
        bif.req = '0;
        @(negedge clk);

        // Redundant set (q already 1) by requester 1.
        check("redund_q", 32'(bif.q), 32'd1);
        e_seen  = 1'b0;
        bif.req = 4'b0010;
        bif.op  = 4'b0010;
        wait_ack(a, er, cyc);
        check("redund_ack", 32'(a), 32'b0010);
        check("redund_err", 32'(er), 32'd0);
`ifdef SR_ARB_SKIP_REDUNDANT_EN
        check("redund_lat", 32'(cyc), 32'd1);
        check("redund_e", 32'(e_seen), 32'd0);
`else
        check("redund_lat", 32'(cyc), 32'd5);
        check("redund_e", 32'(e_seen), 32'd1);
`endif
        bif.req = '0;
        @(negedge clk);
        check("final_busy", 32'(bif.busy), 32'd0);
        check("final_ack", 32'(bif.ack), 32'd0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sr_latch_arbiter.md
Name: sr_latch_arbiter

Overview:
- Round-robin controller that shares one gated SR latch (s, r, e in; q from latch) among NREQ requesters.
- Each requester asks to set or reset the latch.
- The block serialises the requests and sequences s/r/e so that s and r are never both 1.
- Enable is only asserted while s/r are stable; the q readback is checked before the requester is acknowledged.
- Sits between the control agents and the SR_LATCH instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PULSE_CYC, 2, cycles e is held high per operation (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- req  input  NREQ  per-requester request level; held until matching ack.
- op  input  NREQ  per-requester operation: 1 = set (q->1), 0 = reset (q->0); sampled at grant.
- ack  output  NREQ  one-hot, one-cycle completion pulse to the granted requester.
- err  output  1  one-cycle pulse with ack when q readback != requested value.
- grant_id  output  clog2(NREQ)  index of the current or last granted requester.
- busy  output  1  high in any state other than IDLE.
- s  output  1  latch set input.
- r  output  1  latch reset input.
- e  output  1  latch enable.
- q  input  1  latch output readback.

Behaviour:
- Reset: on a clk edge with rst=1, all of the following are cleared:
  - outputs ack=0, err=0, grant_id=0, busy=0, s=0, r=0, e=0
  - state=IDLE, round-robin pointer=0, pulse counter=0.
- rst mid-operation aborts at that edge, with the same values; the aborted requester gets no ack.
- FSM states: IDLE, SETUP, PULSE, HOLD, CHECK.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from the pointer, modulo NREQ.
  - Latch grant_id and op[grant] into an internal op_q.
  - Next state is SETUP. With no request, stay in IDLE and drive s=r=e=0.
- SETUP (1 cycle): s=op_q, r=~op_q, e=0. Next state is PULSE.
- PULSE (PULSE_CYC cycles): s/r unchanged, e=1. A counter counts PULSE_CYC cycles, then next state is HOLD.
- HOLD (1 cycle): e=0, s/r unchanged (hold time after the enable falls). Next state is CHECK.
- CHECK (1 cycle):
  - s=r=e=0.
  - ack[grant_id]=1; err=(q != op_q).
  - Pointer = grant_id+1, wrapping to 0 past NREQ-1. Next state is IDLE.
- Latency: req seen in IDLE at edge N, then ack is high during cycle N+PULSE_CYC+3 (default: 5 cycles after grant).
- Back-to-back: a pending request is granted in the IDLE cycle that follows CHECK. Minimum turnaround is PULSE_CYC+4 cycles per operation.
- Invariants, checked every cycle:
  - s&r == 0.
  - e=1 only in PULSE.
  - ack is at most one-hot and only in CHECK.
  - err only with ack.
- Requests are not pre-emptive: req/op changes during SETUP..CHECK are ignored. If the granted req drops early, the operation still completes and ack is still pulsed.
- Simultaneous requests: strict round-robin from the pointer. No requester waits more than NREQ-1 operations.
- Wrap-around: with pointer=NREQ-1 and req bits 0 and NREQ-1 both set, NREQ-1 is granted; the next grant goes to 0.
- grant_id holds its last value while IDLE.

Optional Feature:
- Macro: SR_ARB_SKIP_REDUNDANT_EN.
- Defined:
  - In IDLE, if the selected op equals the current q, skip SETUP/PULSE/HOLD and go directly to CHECK on the next cycle (ack 1 cycle after grant, err=0).
  - s/r/e stay 0 throughout; the pointer advances as normal.
- Undefined: every grant runs the full sequence regardless of q.

Test Plan:
- rst=1 for 2 cycles, then deasserted with req=0 -> all outputs 0, busy=0, state stays IDLE for 10 cycles.
- req=4'b0001, op=4'b0001, latch model attached -> SETUP: s=1 r=0 e=0; then e=1 for 2 cycles; HOLD: e=0; ack=4'b0001 at grant+5, q=1, err=0.
- req=4'b1111 held, op alternating 1/0 per requester -> grant order 0,1,2,3,0; each ack one-hot; q toggles 1,0,1,0,1; s&r never 1.
- Latch model forced stuck at q=0, req=4'b0100, op[2]=1 -> ack=4'b0100 with err=1 in the same cycle.
- Assert rst during PULSE of a grant to requester 1 -> next cycle s=r=e=0, busy=0, no ack; re-request is served from pointer 0.
- With SR_ARB_SKIP_REDUNDANT_EN defined, q=1, req=4'b0010, op[1]=1 -> e never asserts, ack=4'b0010 one cycle after grant. Undefined -> full 5-cycle sequence.
